// File: rtl/stdp_update_sched.sv
// STDP update scheduler: on a postsynaptic spike rise it walks every synapse,
// lets the time-difference datapath settle, and writes back one saturated weight.
//
// state  | meaning
// IDLE   | waiting for a trigger, sel parked at 0
// SETTLE | holding sel while td_in / weight_rd_data settle
// WRITE  | one-cycle write strobe for the current synapse
// DONE   | one-cycle done pulse; may chain straight into a pending scan
module stdp_update_sched #(
   parameter int N_SYN      = 16,
   parameter int SEL_W      = 4,
   parameter int W_W        = 4,
   parameter int DT_W       = 3,
   parameter int SETTLE_CYC = 2
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   enable,
   input  logic                   post_spike,
   input  logic signed [DT_W-1:0] td_in,
   input  logic [W_W-1:0]         weight_rd_data,
   output logic [SEL_W-1:0]       sel,
   output logic                   weight_wr_en,
   output logic [SEL_W-1:0]       weight_wr_addr,
   output logic [W_W-1:0]         weight_wr_data,
   output logic                   busy,
   output logic                   done,
   output logic [7:0]             missed_cnt
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETTLE = 2'd1;
   localparam logic [1:0] S_WRITE  = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   localparam int SUM_W = W_W + 2;
   localparam int CNT_W = $clog2(SETTLE_CYC + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE_CYC - 1);
   localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N_SYN - 1);

   logic [1:0]       state;
   logic [CNT_W-1:0] settle_cnt;
   logic             pending;
   logic             post_prev;
   logic             trigger;
   logic [SUM_W-1:0] td_ext;
   logic [SUM_W-1:0] sum;
   logic [W_W-1:0]   new_w;
   logic [7:0]       missed_inc;

   assign trigger    = post_spike & ~post_prev & enable;
   assign missed_inc = (missed_cnt == 8'hFF) ? missed_cnt : missed_cnt + 8'd1;

   // Saturating add of the signed time difference onto the unsigned weight.
   always_comb begin
      td_ext = {{(SUM_W-DT_W){td_in[DT_W-1]}}, td_in};
      sum    = td_ext + {2'b00, weight_rd_data};
      if (sum[SUM_W-1])
         new_w = '0;
      else if (|sum[SUM_W-2:W_W])
         new_w = '1;
      else
         new_w = sum[W_W-1:0];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= S_IDLE;
         settle_cnt     <= '0;
         pending        <= 1'b0;
         post_prev      <= 1'b0;
         sel            <= '0;
         weight_wr_en   <= 1'b0;
         weight_wr_addr <= '0;
         weight_wr_data <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         missed_cnt     <= '0;
      end else begin
         post_prev    <= post_spike;
         weight_wr_en <= 1'b0;
         done         <= 1'b0;

         case (state)
            S_IDLE: begin
               busy <= 1'b0;
               sel  <= '0;
               if (trigger) begin
                  state      <= S_SETTLE;
                  settle_cnt <= '0;
                  busy       <= 1'b1;
               end
            end

            S_SETTLE: begin
               if (trigger) begin
                  if (pending) missed_cnt <= missed_inc;
                  else         pending    <= 1'b1;
               end
               // The sample is taken at the settle end and the write registered
               // here, so the strobe lines up exactly with the WRITE cycle.
               if (settle_cnt == LAST_CNT) begin
                  state          <= S_WRITE;
                  weight_wr_en   <= (td_in != '0);
                  weight_wr_addr <= sel;
                  if (td_in != '0)
                     weight_wr_data <= new_w;
               end else begin
                  settle_cnt <= settle_cnt + 1'b1;
               end
            end

            S_WRITE: begin
               if (trigger) begin
                  if (pending) missed_cnt <= missed_inc;
                  else         pending    <= 1'b1;
               end
               settle_cnt <= '0;
               if (sel == LAST_SEL) begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end else begin
                  sel   <= sel + 1'b1;
                  state <= S_SETTLE;
               end
            end

            S_DONE: begin
               if (trigger && pending)
                  missed_cnt <= missed_inc;
               pending    <= 1'b0;
               sel        <= '0;
               settle_cnt <= '0;
               // A fresh trigger in this cycle counts as pending and chains on.
               if ((pending || trigger) && enable) begin
                  state <= S_SETTLE;
                  busy  <= 1'b1;
               end else begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            end

            default: begin
               state      <= S_IDLE;
               settle_cnt <= '0;
               pending    <= 1'b0;
               sel        <= '0;
               busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule
